capture_scheduler: RTL and testbench
====================================

Name: capture_scheduler

Overview:
- Sequences one acquisition cycle around the sampler (arm → capture → hold → readout) and owns the single-port 256×8 sample RAM.
- Arbitrates the RAM between sampler writes and a host/display read requester.
- Rotates read addresses so logical index 0 is the oldest stored sample.
- Sits between the host command decoder, the sampler and the sample RAM.

Parameters:
SAMPLE_DEPTH, 8, address width; buffer holds 2^SAMPLE_DEPTH samples
HOLDOFF_CYCLES, 1024, clk_50mhz cycles in HOLD before the buffer becomes READY
CNT_W, 16, width of holdoff counter (must hold HOLDOFF_CYCLES)

Ports:
clk_50mhz  in  1  single system clock
reset  in  1  asynchronous, active-low reset
arm  in  1  level-sampled pulse: start an acquisition
auto_mode  in  1  1 = re-arm automatically after a completed readout
abort  in  1  pulse: cancel any activity, return to IDLE
smp_activate  out  1  drive to sampler; held high while CAPTURE
smp_done  in  1  sampler completion pulse
smp_we  in  1  sampler write enable
smp_addr  in  SAMPLE_DEPTH  sampler write address
smp_data  in  8  sampler write data
mem_addr  out  SAMPLE_DEPTH  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  8  RAM read data, valid 1 cycle after address
rd_req  in  1  read request for rd_index
rd_index  in  SAMPLE_DEPTH  logical sample index (0 = oldest)
rd_valid  out  1  rd_data valid pulse
rd_data  out  8  returned sample
rd_reject  out  1  pulse: rd_req refused (buffer not READY)
ready  out  1  buffer complete and readable
busy  out  1  high in CAPTURE or HOLD

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0; oldest_ptr 0; holdoff counter 0.
- States: IDLE, CAPTURE, HOLD, READY.
- IDLE: arm → CAPTURE. smp_activate rises the cycle after arm is seen.
- CAPTURE: RAM mux selects sampler (mem_addr = smp_addr, mem_wdata = smp_data, mem_we = smp_we), registered with 1-cycle latency. On smp_done: latch oldest_ptr = last written smp_addr + 1 (mod 2^SAMPLE_DEPTH), drop smp_activate, go to HOLD.
- HOLD: mem_we = 0. Counter counts 0..HOLDOFF_CYCLES-1, then READY. HOLDOFF_CYCLES = 0 → straight to READY the next cycle.
- READY: ready = 1.
  - rd_req → mem_addr = oldest_ptr + rd_index (wraps mod 2^SAMPLE_DEPTH); rd_valid and rd_data = mem_rdata exactly 2 cycles after rd_req.
  - rd_req accepted every cycle, fully pipelined.
  - arm → CAPTURE, ready drops; in-flight reads still complete.
  - Readout completion = accepted rd_req with rd_index = 2^SAMPLE_DEPTH-1. If auto_mode = 1, go to CAPTURE the cycle after that last read's rd_valid.
- rd_req in any state other than READY: rd_reject pulses 1 cycle later, no RAM access, rd_valid stays 0.
- abort (any state, highest priority): smp_activate = 0, mem_we = 0, pending reads discarded (no rd_valid), state IDLE next cycle.
- arm while CAPTURE/HOLD: ignored.
- smp_done outside CAPTURE: ignored.
- Simultaneous arm + rd_req in READY: read serviced, then CAPTURE.
- Sampler writes arriving outside CAPTURE never reach the RAM.
- Reset mid-capture: immediate return to IDLE with smp_activate = 0. RAM contents undefined to readers; ready = 0.

Decomposition:
- Package capture_pkg: state enum (ST_IDLE, ST_CAPTURE, ST_HOLD, ST_READY), SAMPLE_DEPTH default, sample_t (8-bit) typedef.
- One sub-module: capture_rd_pipe. Holds the rotation adder plus the 2-stage rd_valid/rd_data pipeline, with a flush input driven by abort.

Test Plan:
- Reset low mid-CAPTURE → smp_activate, mem_we, ready, busy = 0 asynchronously; state IDLE.
- arm; sampler writes addr 0..255 data = addr, last write addr 0x5A, smp_done; HOLDOFF_CYCLES = 4 → ready high 5 cycles after smp_done. rd_index 0 → rd_data 0x5B; rd_index 255 → 0x5A; each 2 cycles after rd_req.
- Back-to-back rd_req, index 0..255, one per cycle → 256 consecutive rd_valid pulses, rd_data = (0x5B + i) mod 256.
- rd_req during CAPTURE → rd_reject pulse next cycle, mem_we pattern unchanged, no rd_valid.
- auto_mode = 1, read index 255 → smp_activate high the cycle after the final rd_valid; arm during CAPTURE has no effect.
- abort 1 cycle after rd_req in READY → no rd_valid, state IDLE, ready = 0.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared types for the acquisition scheduler.
// State encoding, sample type and default buffer depth.
package capture_pkg;

  localparam int SAMPLE_DEPTH_DFLT = 8;

  typedef logic [7:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HOLD,
    ST_READY
  } state_t;

endpackage

// File: rtl/capture_rd_pipe.sv
// capture_rd_pipe: rotated read addressing for readout.
// Two-stage valid pipeline aligned to the RAM read latency.
module capture_rd_pipe
  import capture_pkg::*;
#(
  parameter int AW = SAMPLE_DEPTH_DFLT
) (
  input  logic          clk_50mhz,
  input  logic          reset,
  input  logic          flush,
  input  logic          accept,
  input  logic [AW-1:0] oldest_ptr,
  input  logic [AW-1:0] rd_index,
  input  sample_t       mem_rdata,
  output logic [AW-1:0] rot_addr,
  output logic          rd_valid,
  output sample_t       rd_data,
  output logic          last_done
);

  logic v1_q;
  logic v2_q;
  logic l1_q;
  logic l2_q;

  assign rot_addr = oldest_ptr + rd_index;

  // Track accepted reads and the final-index marker through the RAM latency
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
    end else begin
      v1_q <= accept;
      l1_q <= accept && (&rd_index);
      v2_q <= v1_q;
      l2_q <= v1_q && l1_q;
    end
  end

  assign rd_valid  = v2_q && !flush;
  assign rd_data   = rd_valid ? mem_rdata : '0;
  assign last_done = rd_valid && l2_q;

endmodule

// File: rtl/capture_scheduler.sv
// capture_scheduler: acquisition sequencer and sample RAM owner.
// Arbitrates RAM between sampler writes and rotated host reads.
module capture_scheduler
  import capture_pkg::*;
#(
  parameter int SAMPLE_DEPTH   = SAMPLE_DEPTH_DFLT,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    auto_mode,
  input  logic                    abort,
  output logic                    smp_activate,
  input  logic                    smp_done,
  input  logic                    smp_we,
  input  logic [SAMPLE_DEPTH-1:0] smp_addr,
  input  sample_t                 smp_data,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output sample_t                 mem_wdata,
  output logic                    mem_we,
  input  sample_t                 mem_rdata,
  input  logic                    rd_req,
  input  logic [SAMPLE_DEPTH-1:0] rd_index,
  output logic                    rd_valid,
  output sample_t                 rd_data,
  output logic                    rd_reject,
  output logic                    ready,
  output logic                    busy
);

  localparam int AW = SAMPLE_DEPTH;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLDOFF_CYCLES == 0) ? '0 : CNT_W'(HOLDOFF_CYCLES - 1);

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   oldest_q;
  logic [AW-1:0]   last_wr_q;
  logic [AW-1:0]   last_addr;
  logic [AW-1:0]   rot_addr;
  logic [CNT_W-1:0] cnt_q;
  logic            cap_sel;
  logic            cap_wr;
  logic            accept;
  logic            last_done;

  assign cap_sel   = (state_q == ST_CAPTURE) && !abort;
  assign cap_wr    = cap_sel && smp_we;
  assign accept    = rd_req && (state_q == ST_READY) && !abort;
  assign last_addr = cap_wr ? smp_addr : last_wr_q;

  // Next-state selection; abort overrides every state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (arm) state_d = ST_CAPTURE;
        ST_CAPTURE: if (smp_done) state_d = ST_HOLD;
        ST_HOLD:    if (cnt_q == HOLD_LAST) state_d = ST_READY;
        ST_READY: begin
          if (arm || (auto_mode && last_done))
            state_d = ST_CAPTURE;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // State, write tracking, rotation base and holdoff counter
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      oldest_q  <= '0;
      last_wr_q <= '1;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cap_wr)
        last_wr_q <= smp_addr;
      if (cap_sel && smp_done)
        oldest_q <= last_addr + 1'b1;
      if (state_q == ST_HOLD)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  // Registered RAM port mux and reject pulse
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_reject <= 1'b0;
    end else begin
      rd_reject <= rd_req && (state_q != ST_READY);
      mem_we    <= 1'b0;
      unique case (1'b1)
        cap_sel: begin
          mem_addr  <= smp_addr;
          mem_wdata <= smp_data;
          mem_we    <= smp_we;
        end
        accept: begin
          mem_addr <= rot_addr;
        end
        default: begin
        end
      endcase
    end
  end

  capture_rd_pipe #(
    .AW (AW)
  ) u_rd_pipe (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .flush      (abort),
    .accept     (accept),
    .oldest_ptr (oldest_q),
    .rd_index   (rd_index),
    .mem_rdata  (mem_rdata),
    .rot_addr   (rot_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .last_done  (last_done)
  );

  assign smp_activate = (state_q == ST_CAPTURE);
  assign busy  = (state_q == ST_CAPTURE) || (state_q == ST_HOLD);
  assign ready = (state_q == ST_READY);

endmodule

// File: tb/tb_capture_scheduler.sv
// tb_capture_scheduler: self-checking bench for capture_scheduler.
// Directed vectors plus randomized captures against a buffer model.
module tb_capture_scheduler;

  logic       clk;
  logic       reset;
  logic       arm;
  logic       auto_mode;
  logic       abort;
  logic       smp_activate;
  logic       smp_done;
  logic       smp_we;
  logic [7:0] smp_addr;
  logic [7:0] smp_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       rd_req;
  logic [7:0] rd_index;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_reject;
  logic       ready;
  logic       busy;

  int checks;
  int failures;

  logic [7:0] ram [256];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_oldest;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    int         due;
    logic [7:0] d;
  } resp_t;

  rd_vec_t vec [8];

  capture_scheduler #(
    .SAMPLE_DEPTH   (8),
    .HOLDOFF_CYCLES (4),
    .CNT_W          (16)
  ) dut (
    .clk_50mhz    (clk),
    .reset        (reset),
    .arm          (arm),
    .auto_mode    (auto_mode),
    .abort        (abort),
    .smp_activate (smp_activate),
    .smp_done     (smp_done),
    .smp_we       (smp_we),
    .smp_addr     (smp_addr),
    .smp_data     (smp_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .rd_req       (rd_req),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_reject    (rd_reject),
    .ready        (ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; smp_done = 0; smp_we = 0; rd_req = 0;
  endtask

  task automatic start_capture();
    chk("pre_act", smp_activate, 0);
    arm = 1;
    tick();
    arm = 0;
    chk("arm_act", smp_activate, 1);
    chk("arm_busy", busy, 1);
    chk("arm_ready", ready, 0);
  endtask

  task automatic start_capture_rd();
    logic [7:0] idx;
    logic [7:0] e;
    idx = 8'($urandom);
    e = exp_mem[8'(exp_oldest + idx)];
    chk("ar_pre_act", smp_activate, 0);
    arm = 1; rd_req = 1; rd_index = idx;
    tick();
    arm = 0; rd_req = 0;
    chk("ar_act", smp_activate, 1);
    chk("ar_rv0", rd_valid, 0);
    tick();
    chk("ar_rv", rd_valid, 1);
    chk("ar_rd", rd_data, e);
    chk("ar_we", mem_we, 0);
  endtask

  // Sampler writes in CAPTURE, then smp_done and holdoff
  task automatic capture_body(input bit seq, input int nwr,
                              input logic [7:0] base);
    int i;
    bit same;
    bit we;
    bit r;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] last;
    i = 0;
    last = 8'hff;
    same = !seq && (($urandom & 1) == 1);
    while (i < nwr) begin
      we = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (i == nwr - 1) we = 1'b1;
      a = seq ? 8'(base + i) : 8'($urandom);
      d = seq ? a : 8'($urandom);
      r = seq ? (i % 37 == 5) : ($urandom_range(0, 7) == 0);
      smp_we = we; smp_addr = a; smp_data = d;
      rd_req = r; rd_index = 8'($urandom);
      arm = seq ? (i % 50 == 7) : ($urandom_range(0, 15) == 0);
      smp_done = same && we && (i == nwr - 1);
      tick();
      chk("cap_we", mem_we, we);
      if (we) begin
        chk("cap_addr", mem_addr, a);
        chk("cap_wdata", mem_wdata, d);
        exp_mem[a] = d;
        last = a;
        i++;
      end
      chk("cap_rej", rd_reject, r);
      chk("cap_rv", rd_valid, 0);
      chk("cap_act", smp_activate, !smp_done);
    end
    if (!same) begin
      smp_we = 0; smp_done = 1; rd_req = 0; arm = 0;
      tick();
      chk("done_we", mem_we, 0);
    end
    exp_oldest = 8'(last + 1);
    chk("done_act", smp_activate, 0);
    chk("done_busy", busy, 1);
    chk("done_ready", ready, 0);
    for (int k = 2; k <= 5; k++) begin
      r = ($urandom_range(0, 3) == 0);
      rd_req = r;
      smp_we = 1'($urandom); smp_addr = 8'($urandom);
      smp_data = 8'($urandom); smp_done = 1'($urandom);
      arm = 1'($urandom);
      tick();
      chk("hold_we", mem_we, 0);
      chk("hold_rej", rd_reject, r);
      chk("hold_ready", ready, k == 5);
      chk("hold_busy", busy, k != 5);
    end
    idle_inputs();
  endtask

  // Random pipelined reads with sampler noise on the inputs
  task automatic read_phase(input int ncyc);
    resp_t q[$];
    bit req;
    logic [7:0] idx;
    for (int c = 0; c < ncyc + 2; c++) begin
      req = (c < ncyc) && ($urandom_range(0, 9) < 6);
      idx = 8'($urandom);
      rd_req = req; rd_index = idx;
      smp_we = 1'($urandom); smp_addr = 8'($urandom);
      smp_data = 8'($urandom); smp_done = 1'($urandom);
      if (req) q.push_back('{c + 2, exp_mem[8'(exp_oldest + idx)]});
      tick();
      if (q.size() > 0 && q[0].due == c + 1) begin
        chk("rp_valid", rd_valid, 1);
        chk("rp_data", rd_data, q[0].d);
        void'(q.pop_front());
      end else begin
        chk("rp_valid", rd_valid, 0);
      end
      chk("rp_we", mem_we, 0);
      chk("rp_rej", rd_reject, 0);
      chk("rp_ready", ready, 1);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_oldest = 0;
    reset = 0; auto_mode = 0; rd_index = 0;
    smp_addr = 0; smp_data = 0;
    idle_inputs();

    vec[0] = '{8'h00, 8'h5B};
    vec[1] = '{8'hFF, 8'h5A};
    vec[2] = '{8'h01, 8'h5C};
    vec[3] = '{8'hA4, 8'hFF};
    vec[4] = '{8'hA5, 8'h00};
    vec[5] = '{8'h10, 8'h6B};
    vec[6] = '{8'h80, 8'hDB};
    vec[7] = '{8'h7F, 8'hDA};

    repeat (2) tick();
    chk("rst_act", smp_activate, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_rej", rd_reject, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    tick();

    start_capture();
    smp_we = 1; smp_addr = 8'h03; smp_data = 8'h77;
    tick();
    chk("mid_we", mem_we, 1);
    #2 reset = 0;
    #1;
    chk("arst_act", smp_activate, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    smp_we = 0;
    reset = 1;
    tick();
    chk("post_rst_act", smp_activate, 0);
    chk("post_rst_busy", busy, 0);

    start_capture();
    capture_body(1'b1, 256, 8'h5B);
    chk("oldest_model", exp_oldest, 8'h5B);

    for (int v = 0; v < 8; v++) begin
      rd_req = 1; rd_index = vec[v].idx;
      tick();
      rd_req = 0;
      chk("tv_early", rd_valid, 0);
      chk("tv_maddr", mem_addr, vec[v].exp);
      tick();
      chk("tv_valid", rd_valid, 1);
      chk("tv_data", rd_data, vec[v].exp);
    end

    for (int i = 0; i <= 256; i++) begin
      rd_req = (i < 256);
      rd_index = 8'(i);
      tick();
      if (i == 0) begin
        chk("bb_first", rd_valid, 0);
      end else begin
        chk("bb_valid", rd_valid, 1);
        chk("bb_data", rd_data, 8'(8'h5B + i - 1));
      end
    end
    rd_req = 0;
    tick();
    chk("bb_tail", rd_valid, 0);
    chk("bb_ready", ready, 1);

    rd_req = 1; rd_index = 8'h20;
    tick();
    rd_req = 0; abort = 1;
    tick();
    abort = 0;
    chk("ab_rv", rd_valid, 0);
    chk("ab_ready", ready, 0);
    chk("ab_busy", busy, 0);
    chk("ab_act", smp_activate, 0);
    tick();
    chk("ab_rv2", rd_valid, 0);
    rd_req = 1;
    tick();
    rd_req = 0;
    chk("idle_rej", rd_reject, 1);
    tick();
    chk("idle_rej_end", rd_reject, 0);
    chk("idle_rv", rd_valid, 0);

    for (int it = 0; it < 5; it++) begin
      if (it == 2) start_capture_rd();
      else start_capture();
      capture_body(1'b0, $urandom_range(10, 300), 8'h00);
      read_phase(60);
    end

    auto_mode = 1;
    rd_req = 1; rd_index = 8'hFF;
    tick();
    rd_req = 0;
    chk("am_rv0", rd_valid, 0);
    tick();
    chk("am_rv", rd_valid, 1);
    chk("am_rd", rd_data, exp_mem[8'(exp_oldest + 8'hFF)]);
    chk("am_act0", smp_activate, 0);
    tick();
    auto_mode = 0;
    chk("am_act", smp_activate, 1);
    chk("am_ready", ready, 0);
    chk("am_busy", busy, 1);
    arm = 1;
    tick();
    arm = 0;
    chk("am_arm_ign", smp_activate, 1);
    capture_body(1'b0, $urandom_range(10, 100), 8'h00);
    read_phase(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
